decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode / operand-fetch stage directly upstream of the integer ALU.
- Accepts 32-bit RV64 instructions over a valid/ready handshake and reads two source registers through a combinational register-file port.
- Produces registered ALU operands: a 4-bit ALU opcode, value1, value2, a 32-bit immediate, a 6-bit shamt, rd, and an illegal flag.
- A 2-entry skid buffer gives full throughput with registered ready.

Parameters:
- XLEN, 64, operand width.
- IMM_W, 32, immediate output width.
- SHAMT_W, 6, shift-amount width.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction valid
- in_ready  output  1  stage can accept instruction
- in_instr  input  32  instruction word
- rs1_addr  output  5  regfile read address 1 = in_instr[19:15], combinational
- rs2_addr  output  5  regfile read address 2 = in_instr[24:20], combinational
- rs1_data  input  XLEN  regfile read data 1, same cycle
- rs2_data  input  XLEN  regfile read data 2, same cycle
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  ALU side accepts bundle
- alu_opcode  output  4  0 NOTHING, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 XOR, 6 AND, 7 OR, 8 REM, 9 NOT, 10 LOGLEFT, 11 LOGRIGHT, 12 ARTHRIGHT
- value1  output  XLEN  first operand
- value2  output  XLEN  second operand
- immediate  output  IMM_W  sign-extended immediate
- shamt  output  SHAMT_W  shift amount
- rd  output  5  destination register
- illegal  output  1  unsupported or illegal encoding

Behaviour:
- Reset (async, on reset_n low): out_valid=0, skid empty, in_ready=0 while asserted and 1 from the first clk edge after release. All data outputs = 0 (alu_opcode=NOTHING). Reset mid-transfer discards both entries; no partial output.
- Transfers: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready at posedge clk.
- Latency: 1 cycle from input transfer to out_valid.
- Operand sampling: rs1_data/rs2_data are sampled in the same cycle as the input transfer. A register address of 0 forces the corresponding operand to 0 regardless of the data input.
- Decode, R-type (opcode 0x33):
  - funct7 0x00, funct3 0/4/6/7/1/5 -> ADD/XOR/OR/AND/LOGLEFT/LOGRIGHT.
  - funct7 0x20, funct3 0 -> SUB; funct3 5 -> ARTHRIGHT.
  - funct7 0x01, funct3 0 -> MUL; 4 -> DIV; 6 -> REM.
  - value2=rs2, immediate=0, shamt=0.
- Decode, I-type ALU (opcode 0x13):
  - funct3 0/4/6/7 -> ADD/XOR/OR/AND.
  - immediate = sign-extended instr[31:20]; value2=0; shamt=0.
- Decode, shift-immediate (opcode 0x13):
  - funct3 1 with instr[31:26]=0 -> LOGLEFT.
  - funct3 5 with instr[31:26]=0x00 -> LOGRIGHT; 0x10 -> ARTHRIGHT.
  - shamt = instr[25:20]; immediate=0; value2=0.
- Operand selection invariant: the ALU picks immediate if nonzero, else shamt if nonzero, else value2. Forcing value2=0 on immediate forms makes a zero immediate or zero shamt yield the correct result.
- Any other encoding: alu_opcode=NOTHING, illegal=1, value1/value2/immediate/shamt=0, rd=instr[11:7]. The bundle still traverses the handshake and is never dropped.
- Skid buffer:
  - Output register empty or draining -> a new input loads the output register.
  - Output register holding and not draining -> a new input loads the skid entry.
  - On drain with skid full, the skid entry moves to the output register the same edge.
  - in_ready is registered = !skid_full.
  - Simultaneous drain and accept with skid full is impossible (in_ready=0).
- Ordering: strict FIFO order; outputs stay stable while out_valid && !out_ready.

Test Plan:
- Reset held, then released, with no input -> out_valid=0, alu_opcode=0, in_ready=1 one cycle after reset_n rises.
- ADDI x1,x2,5 (0x00510093), rs2_addr ignored, rs1_data=10 -> next cycle: alu_opcode=1, value1=10, value2=0, immediate=5, shamt=0, rd=1.
- SUB x3,x1,x2 (0x402081B3), rs1_data=7, rs2_data=9 -> alu_opcode=2, value1=7, value2=9, immediate=0, rd=3.
- SLLI x5,x6,63 (0x03F31293) -> alu_opcode=10, shamt=63, immediate=0, value2=0, rd=5.
- Backpressure: out_ready=0 for 3 cycles while ADD (0x002081B3) then MUL (0x022081B3) are offered -> both accepted, in_ready falls to 0. Release out_ready -> opcodes 1 then 3 in order, no loss or duplication.
- Word 0xFFFFFFFF, and ADD with rs1=x0 and rs1_data=0xDEAD -> first gives illegal=1, alu_opcode=0; second gives value1=0.

Source files
------------

// File: rtl/decode_if.sv
// Handshake and operand bus between the decode stage, its upstream instruction source,
// the register-file read port and the downstream ALU.
interface decode_if #(
   parameter int XLEN    = 64,
   parameter int IMM_W   = 32,
   parameter int SHAMT_W = 6
);
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_instr;
   logic [4:0]         rs1_addr;
   logic [4:0]         rs2_addr;
   logic [XLEN-1:0]    rs1_data;
   logic [XLEN-1:0]    rs2_data;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         alu_opcode;
   logic [XLEN-1:0]    value1;
   logic [XLEN-1:0]    value2;
   logic [IMM_W-1:0]   immediate;
   logic [SHAMT_W-1:0] shamt;
   logic [4:0]         rd;
   logic               illegal;

   modport slave (
      input  in_valid, in_instr, rs1_data, rs2_data, out_ready,
      output in_ready, rs1_addr, rs2_addr, out_valid, alu_opcode,
             value1, value2, immediate, shamt, rd, illegal
   );

   modport master (
      output in_valid, in_instr, rs1_data, rs2_data, out_ready,
      input  in_ready, rs1_addr, rs2_addr, out_valid, alu_opcode,
             value1, value2, immediate, shamt, rd, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV64 integer decode / operand-fetch stage feeding the ALU, with a 2-entry skid buffer
// (output register + skid register) so that in_ready can be registered.
module decode_stage #(
   parameter int XLEN    = 64,
   parameter int IMM_W   = 32,
   parameter int SHAMT_W = 6
) (
   input  logic    clk,
   input  logic    reset_n,
   decode_if.slave bus
);
   typedef enum logic [3:0] {
      OP_NOTHING = 4'd0,  OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4,
      OP_XOR = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7, OP_REM = 4'd8, OP_NOT = 4'd9,
      OP_LOGLEFT = 4'd10, OP_LOGRIGHT = 4'd11, OP_ARTHRIGHT = 4'd12
   } alu_op_e;

   typedef struct packed {
      logic [3:0]         opcode;
      logic [XLEN-1:0]    v1;
      logic [XLEN-1:0]    v2;
      logic [IMM_W-1:0]   imm;
      logic [SHAMT_W-1:0] shamt;
      logic [4:0]         rd;
      logic               illegal;
   } bundle_t;

   logic [31:0] instr;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   alu_op_e     op_sel;
   logic        is_r, is_i, is_s;
   logic [XLEN-1:0] src1, src2;
   bundle_t     dec;

   bundle_t out_q, out_d, skid_q, skid_d;
   logic    out_valid_q, out_valid_d, skid_full_q, skid_full_d, in_ready_q;
   logic    accept, drain;

   assign instr         = bus.in_instr;
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign bus.rs1_addr  = instr[19:15];
   assign bus.rs2_addr  = instr[24:20];
   assign src1          = (instr[19:15] == 5'd0) ? '0 : bus.rs1_data;
   assign src2          = (instr[24:20] == 5'd0) ? '0 : bus.rs2_data;

   always_comb begin
      op_sel = OP_NOTHING;
      is_r   = 1'b0;
      is_i   = 1'b0;
      is_s   = 1'b0;
      if (instr[6:0] == 7'h33) begin
         is_r = 1'b1;
         case ({funct7, funct3})
            {7'h00, 3'd0}: op_sel = OP_ADD;
            {7'h00, 3'd4}: op_sel = OP_XOR;
            {7'h00, 3'd6}: op_sel = OP_OR;
            {7'h00, 3'd7}: op_sel = OP_AND;
            {7'h00, 3'd1}: op_sel = OP_LOGLEFT;
            {7'h00, 3'd5}: op_sel = OP_LOGRIGHT;
            {7'h20, 3'd0}: op_sel = OP_SUB;
            {7'h20, 3'd5}: op_sel = OP_ARTHRIGHT;
            {7'h01, 3'd0}: op_sel = OP_MUL;
            {7'h01, 3'd4}: op_sel = OP_DIV;
            {7'h01, 3'd6}: op_sel = OP_REM;
            default:       op_sel = OP_NOTHING;
         endcase
      end else if (instr[6:0] == 7'h13) begin
         case (funct3)
            3'd0: begin op_sel = OP_ADD; is_i = 1'b1; end
            3'd4: begin op_sel = OP_XOR; is_i = 1'b1; end
            3'd6: begin op_sel = OP_OR;  is_i = 1'b1; end
            3'd7: begin op_sel = OP_AND; is_i = 1'b1; end
            3'd1: begin
               is_s = 1'b1;
               if (instr[31:26] == 6'h00) op_sel = OP_LOGLEFT;
            end
            3'd5: begin
               is_s = 1'b1;
               if (instr[31:26] == 6'h00)      op_sel = OP_LOGRIGHT;
               else if (instr[31:26] == 6'h10) op_sel = OP_ARTHRIGHT;
            end
            default: op_sel = OP_NOTHING;
         endcase
      end
   end

   // value2 stays 0 on immediate forms so the ALU's imm/shamt/value2 priority picks correctly.
   always_comb begin
      dec         = '0;
      dec.rd      = instr[11:7];
      dec.illegal = 1'b1;
      if (op_sel != OP_NOTHING) begin
         dec.illegal = 1'b0;
         dec.opcode  = op_sel;
         dec.v1      = src1;
         if (is_r) dec.v2    = src2;
         if (is_i) dec.imm   = {{(IMM_W-12){instr[31]}}, instr[31:20]};
         if (is_s) dec.shamt = instr[20 +: SHAMT_W];
      end
   end

   assign accept = bus.in_valid && in_ready_q;
   assign drain  = out_valid_q && bus.out_ready;

   // A full skid implies in_ready_q=0, so drain-with-skid never coincides with accept.
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
      if (drain && skid_full_q) begin
         out_d       = skid_q;
         skid_full_d = 1'b0;
      end else if (accept && (!out_valid_q || drain)) begin
         out_d       = dec;
         out_valid_d = 1'b1;
      end else if (accept) begin
         skid_d      = dec;
         skid_full_d = 1'b1;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         skid_full_q <= skid_full_d;
         in_ready_q  <= !skid_full_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.alu_opcode = out_q.opcode;
   assign bus.value1     = out_q.v1;
   assign bus.value2     = out_q.v2;
   assign bus.immediate  = out_q.imm;
   assign bus.shamt      = out_q.shamt;
   assign bus.rd         = out_q.rd;
   assign bus.illegal    = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed spec cases, then randomized traffic
// against a table-driven reference model and an in-flight queue.
module tb_decode_stage;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   decode_if bus ();
   decode_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   typedef struct {
      logic [3:0]  op;
      logic [63:0] v1, v2;
      logic [31:0] imm;
      logic [5:0]  sh;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   rdy_m = 1'b0;
   int   r_tab[int];
   int   i_tab[int];
   int   s_tab[int];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w, input logic [63:0] d1, input logic [63:0] d2);
      exp_t e;
      int   op;
      int   f3;
      op    = 0;
      f3    = int'(w[14:12]);
      e.op  = 4'd0; e.v1 = '0; e.v2 = '0; e.imm = '0; e.sh = '0;
      e.rd  = w[11:7];
      e.ill = 1'b1;
      if (w[6:0] == 7'h33) begin
         if (r_tab.exists(int'(w[31:25]) * 8 + f3)) begin
            op   = r_tab[int'(w[31:25]) * 8 + f3];
            e.v2 = (w[24:20] == 5'd0) ? 64'd0 : d2;
         end
      end else if (w[6:0] == 7'h13) begin
         if (i_tab.exists(f3)) begin
            op    = i_tab[f3];
            e.imm = 32'($signed(w[31:20]));
         end else if (s_tab.exists(int'(w[31:26]) * 8 + f3)) begin
            op   = s_tab[int'(w[31:26]) * 8 + f3];
            e.sh = w[25:20];
         end
      end
      if (op != 0) begin
         e.op  = 4'(op);
         e.ill = 1'b0;
         e.v1  = (w[19:15] == 5'd0) ? 64'd0 : d1;
      end
      return e;
   endfunction

   // One clock: check outputs against the model, book transfers, advance to next negedge.
   task automatic cycle();
      exp_t h;
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'(rdy_m));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("rs1_addr", 64'(bus.rs1_addr), 64'(bus.in_instr[19:15]));
      chk("rs2_addr", 64'(bus.rs2_addr), 64'(bus.in_instr[24:20]));
      if (q.size() > 0) begin
         h = q[0];
         chk("alu_opcode", 64'(bus.alu_opcode), 64'(h.op));
         chk("value1", bus.value1, h.v1);
         chk("value2", bus.value2, h.v2);
         chk("immediate", 64'(bus.immediate), 64'(h.imm));
         chk("shamt", 64'(bus.shamt), 64'(h.sh));
         chk("rd", 64'(bus.rd), 64'(h.rd));
         chk("illegal", 64'(bus.illegal), 64'(h.ill));
         if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && rdy_m) q.push_back(model(bus.in_instr, bus.rs1_data, bus.rs2_data));
      @(posedge clk);
      @(negedge clk);
      rdy_m = (q.size() < 2);
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      reset_n = 1'b0;
      q.delete();
      rdy_m = 1'b0;
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_opcode", 64'(bus.alu_opcode), 64'd0);
      chk("rst_value1", bus.value1, 64'd0);
      chk("rst_immediate", 64'(bus.immediate), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  f7;
      logic [5:0]  t6;
      case ($urandom_range(0, 3))
         0: w = $urandom;
         1: begin
            case ($urandom_range(0, 3))
               0: f7 = 7'h00;
               1: f7 = 7'h20;
               2: f7 = 7'h01;
               default: f7 = 7'($urandom);
            endcase
            w = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
         end
         2: w = {12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h13};
         default: begin
            case ($urandom_range(0, 2))
               0: t6 = 6'h00;
               1: t6 = 6'h10;
               default: t6 = 6'($urandom);
            endcase
            w = {t6, 6'($urandom), 5'($urandom), $urandom_range(0, 1) ? 3'd1 : 3'd5, 5'($urandom), 7'h13};
         end
      endcase
      return w;
   endfunction

   initial begin
      r_tab[0] = 1;   r_tab[4] = 5;   r_tab[6] = 7;   r_tab[7] = 6;   r_tab[1] = 10; r_tab[5] = 11;
      r_tab[256] = 2; r_tab[261] = 12; r_tab[8] = 3;  r_tab[12] = 4;  r_tab[14] = 8;
      i_tab[0] = 1;   i_tab[4] = 5;   i_tab[6] = 7;   i_tab[7] = 6;
      s_tab[1] = 10;  s_tab[5] = 11;  s_tab[133] = 12;

      bus.in_valid = 1'b0; bus.in_instr = '0; bus.rs1_data = '0; bus.rs2_data = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      do_reset();
      cycle();

      // ADDI x1,x2,5
      bus.in_valid = 1'b1; bus.in_instr = 32'h00510093;
      bus.rs1_data = 64'd10; bus.rs2_data = {$urandom, $urandom};
      cycle();
      bus.in_valid = 1'b0;
      chk("addi_op", 64'(bus.alu_opcode), 64'd1);
      chk("addi_v1", bus.value1, 64'd10);
      chk("addi_v2", bus.value2, 64'd0);
      chk("addi_imm", 64'(bus.immediate), 64'd5);
      chk("addi_sh", 64'(bus.shamt), 64'd0);
      chk("addi_rd", 64'(bus.rd), 64'd1);
      cycle();

      // SUB x3,x1,x2
      bus.in_valid = 1'b1; bus.in_instr = 32'h402081B3;
      bus.rs1_data = 64'd7; bus.rs2_data = 64'd9;
      cycle();
      bus.in_valid = 1'b0;
      chk("sub_op", 64'(bus.alu_opcode), 64'd2);
      chk("sub_v1", bus.value1, 64'd7);
      chk("sub_v2", bus.value2, 64'd9);
      chk("sub_imm", 64'(bus.immediate), 64'd0);
      chk("sub_rd", 64'(bus.rd), 64'd3);
      cycle();

      // SLLI x5,x6,63
      bus.in_valid = 1'b1; bus.in_instr = 32'h03F31293;
      bus.rs1_data = {$urandom, $urandom}; bus.rs2_data = {$urandom, $urandom};
      cycle();
      bus.in_valid = 1'b0;
      chk("slli_op", 64'(bus.alu_opcode), 64'd10);
      chk("slli_sh", 64'(bus.shamt), 64'd63);
      chk("slli_imm", 64'(bus.immediate), 64'd0);
      chk("slli_v2", bus.value2, 64'd0);
      chk("slli_rd", 64'(bus.rd), 64'd5);
      cycle();

      // Backpressure: ADD then MUL fill output + skid
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3;
      bus.rs1_data = {$urandom, $urandom}; bus.rs2_data = {$urandom, $urandom};
      cycle();
      bus.in_instr = 32'h022081B3;
      cycle();
      bus.in_valid = 1'b0;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      cycle();
      bus.out_ready = 1'b1;
      chk("bp_first", 64'(bus.alu_opcode), 64'd1);
      cycle();
      chk("bp_second", 64'(bus.alu_opcode), 64'd3);
      chk("bp_second_valid", 64'(bus.out_valid), 64'd1);
      cycle();
      chk("bp_empty", 64'(bus.out_valid), 64'd0);

      // Illegal word, then ADD with rs1=x0
      bus.in_valid = 1'b1; bus.in_instr = 32'hFFFFFFFF;
      cycle();
      bus.in_instr = 32'h002001B3; bus.rs1_data = 64'hDEAD;
      cycle();
      bus.in_valid = 1'b0;
      chk("x0_op", 64'(bus.alu_opcode), 64'd1);
      chk("x0_v1", bus.value1, 64'd0);
      cycle();

      bus.in_valid = 1'b1; bus.in_instr = 32'hFFFFFFFF;
      cycle();
      bus.in_valid = 1'b0;
      chk("ill_flag", 64'(bus.illegal), 64'd1);
      chk("ill_op", 64'(bus.alu_opcode), 64'd0);
      chk("ill_rd", 64'(bus.rd), 64'd31);
      cycle();

      // Reset with both entries occupied
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_instr = 32'h00510093;
      cycle();
      bus.in_instr = 32'h402081B3;
      cycle();
      do_reset();
      bus.out_ready = 1'b1;
      cycle();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.in_instr  = rand_instr();
         bus.rs1_data  = {$urandom, $urandom};
         bus.rs2_data  = {$urandom, $urandom};
         cycle();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (4) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
